// File: rtl/cnn_pkg.sv
// Shared types for the streaming window builder: pixel/window types,
// builder FSM states and the window packing helper.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int MAX_K  = 5;
    localparam int WIN_N  = MAX_K * MAX_K;

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef pixel_t [0:WIN_N-1]       window_t;
    typedef pixel_t [0:MAX_K-1]       grid_row_t;
    typedef grid_row_t [0:MAX_K-1]    grid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } builder_state_t;

    // A 3x3 window is the bottom-right corner of the 5x5 register grid.
    function automatic window_t pack_window(input grid_t g, input logic k3);
        window_t w;
        w = '0;
        if (k3) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w[r*3+c] = g[r+2][c+2];
                end
            end
        end else begin
            for (int r = 0; r < MAX_K; r++) begin
                for (int c = 0; c < MAX_K; c++) begin
                    w[r*MAX_K+c] = g[r][c];
                end
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of delay: the value read at a column is the pixel written
// at that same column one row earlier.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  pixel_t                   din,
    output pixel_t                   dout
);

    pixel_t mem_r [0:DEPTH-1];

    assign dout = mem_r[idx];

    // Row storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_r[idx] <= din;
        end
    end

endmodule

// File: rtl/conv_window_builder.sv
// Builds sliding 3x3/5x5 windows from a raster pixel stream using a chain of
// line buffers and a 5x5 shift grid, with a single-entry registered output.
module conv_window_builder
    import cnn_pkg::*;
#(
    parameter int MAX_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] filter_size,
    input  logic [15:0] img_w,
    input  logic [15:0] img_h,
    input  logic        in_valid,
    input  pixel_t      in_data,
    output logic        in_ready,
    output logic        out_valid,
    output window_t     out_window,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int AW = $clog2(MAX_W);

    builder_state_t state_r;
    logic           k3_r;
    logic [15:0]    w_r;
    logic [15:0]    h_r;
    logic [15:0]    row_r;
    logic [15:0]    col_r;
    logic           out_valid_r;
    window_t        out_window_r;
    logic           done_r;
    grid_t          win_r;
    grid_t          win_nx_s;
    pixel_t         taps_s [0:MAX_K-1];
    logic           acc_s;
    logic           emit_s;
    logic           last_s;
    logic [15:0]    kmin_s;

    assign in_ready   = (state_r == RUN) && !(out_valid_r && !out_ready);
    assign out_valid  = out_valid_r;
    assign out_window = out_window_r;
    assign done       = done_r;
    assign busy       = (state_r != IDLE);

    assign acc_s  = in_valid && in_ready;
    assign kmin_s = k3_r ? 16'd2 : 16'd4;
    assign emit_s = acc_s && (row_r >= kmin_s) && (col_r >= kmin_s);
    assign last_s = (row_r == h_r - 16'd1) && (col_r == w_r - 16'd1);

    // taps_s[i] is the pixel i rows above the incoming one, same column.
    assign taps_s[0] = in_data;
    for (genvar i = 0; i < MAX_K - 1; i++) begin : g_lb
        line_buffer #(.DEPTH(MAX_W)) u_lb (
            .clk  (clk),
            .en   (acc_s),
            .idx  (col_r[AW-1:0]),
            .din  (taps_s[i]),
            .dout (taps_s[i+1])
        );
    end

    // Next grid: shift left one column, new right column from the taps.
    always_comb begin
        win_nx_s = win_r;
        for (int r = 0; r < MAX_K; r++) begin
            for (int c = 0; c < MAX_K - 1; c++) begin
                win_nx_s[r][c] = win_r[r][c+1];
            end
            win_nx_s[r][MAX_K-1] = taps_s[MAX_K-1-r];
        end
    end

    // Window shift register, advanced on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r <= '0;
        end else if (acc_s) begin
            win_r <= win_nx_s;
        end
    end

    // Frame control FSM, raster counters and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            k3_r         <= 1'b0;
            w_r          <= 16'd0;
            h_r          <= 16'd0;
            row_r        <= 16'd0;
            col_r        <= 16'd0;
            out_valid_r  <= 1'b0;
            out_window_r <= '0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (emit_s) begin
                out_valid_r  <= 1'b1;
                out_window_r <= pack_window(win_nx_s, k3_r);
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        k3_r    <= (filter_size == 16'd3);
                        w_r     <= img_w;
                        h_r     <= img_h;
                        row_r   <= 16'd0;
                        col_r   <= 16'd0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (acc_s) begin
                        if (col_r == w_r - 16'd1) begin
                            col_r <= 16'd0;
                            row_r <= row_r + 16'd1;
                        end else begin
                            col_r <= col_r + 16'd1;
                        end
                        if (last_s) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!out_valid_r || out_ready) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_builder.sv
// Self-checking bench: table of frame configurations driven with random
// handshakes and compared against a raster-order golden window list.
module tb_conv_window_builder;
    import cnn_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] filter_size = 16'd0;
    logic [15:0] img_w = 16'd0;
    logic [15:0] img_h = 16'd0;
    logic        in_valid = 1'b0;
    pixel_t      in_data = '0;
    logic        in_ready;
    logic        out_valid;
    window_t     out_window;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] fs;
        logic [15:0] w;
        logic [15:0] h;
        int          vpct;
        int          rpct;
        bit          pat;
        int          hold;
        bit          restart;
        int          exp_win;
        int          exp_busy;
    } vec_t;

    vec_t    tbl [0:8];
    pixel_t  img [0:1023];
    window_t exp_q [$];

    conv_window_builder #(.MAX_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .filter_size (filter_size),
        .img_w       (img_w),
        .img_h       (img_h),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_window  (out_window),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int id);
        int k, total, pix, wi, dones, busy_cnt, cyc, hold_left, tail;
        bit hold_done, acc;
        window_t held, e;
        k = (v.fs == 16'd3) ? 3 : 5;
        total = int'(v.w) * int'(v.h);
        for (int i = 0; i < total; i++) begin
            if (v.pat) img[i] = pixel_t'($urandom);
            else       img[i] = pixel_t'((i / int'(v.w)) * 16 + (i % int'(v.w)));
        end
        // Golden list: every position with a full KxK neighbourhood, raster order.
        exp_q.delete();
        for (int r = k - 1; r < int'(v.h); r++) begin
            for (int c = k - 1; c < int'(v.w); c++) begin
                e = '0;
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++)
                        e[i*k+j] = img[(r-k+1+i)*int'(v.w) + (c-k+1+j)];
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        filter_size = v.fs; img_w = v.w; img_h = v.h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pix = 0; wi = 0; dones = 0; busy_cnt = 0; cyc = 0;
        hold_left = 0; hold_done = 0; tail = -1; held = '0;
        while (cyc < 5000 && tail != 0) begin
            if (out_valid && !hold_done && v.hold > 0) begin
                hold_left = v.hold; hold_done = 1; held = out_window;
            end
            if (v.restart && cyc == 10) begin
                start = 1'b1; filter_size = 16'd3; img_w = 16'd4; img_h = 16'd4;
            end else begin
                start = 1'b0; filter_size = v.fs; img_w = v.w; img_h = v.h;
            end
            in_valid  = (pix < total) && ($urandom_range(0, 99) < v.vpct);
            in_data   = (pix < total) ? img[pix] : '0;
            out_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(0, 99) < v.rpct);
            #1;
            if (busy) busy_cnt++;
            if (hold_left > 0) begin
                chk($sformatf("f%0d hold in_ready", id), in_ready, 1'b0);
                chk($sformatf("f%0d hold window", id), out_window, held);
                hold_left--;
            end
            if (out_valid && out_ready) begin
                if (wi < exp_q.size())
                    chk($sformatf("f%0d window %0d", id, wi), out_window, exp_q[wi]);
                else
                    chk($sformatf("f%0d extra window", id), 1'b1, 1'b0);
                wi++;
            end
            if (done) begin
                dones++;
                tail = 4;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) pix++;
            @(negedge clk);
            cyc++;
            if (tail > 0) tail--;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk($sformatf("f%0d finished in budget", id), (cyc < 5000), 1'b1);
        chk($sformatf("f%0d window count", id), wi, v.exp_win);
        chk($sformatf("f%0d done pulses", id), dones, 1);
        chk($sformatf("f%0d pixels taken", id), pix, total);
        chk($sformatf("f%0d busy low", id), busy, 1'b0);
        if (v.exp_busy > 0)
            chk($sformatf("f%0d busy cycles", id), busy_cnt, v.exp_busy);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, " out_valid"}, out_valid, 1'b0);
        chk({nm, " in_ready"}, in_ready, 1'b0);
        chk({nm, " busy"}, busy, 1'b0);
        chk({nm, " done"}, done, 1'b0);
        chk({nm, " out_window"}, out_window, '0);
    endtask

    initial begin
        //           fs     w      h     vpct rpct pat hold rst win busy
        tbl[0] = '{16'd3, 16'd8,  16'd8, 100, 100, 0,  0,  0, 36, 66};
        tbl[1] = '{16'd5, 16'd6,  16'd6, 100, 100, 0,  0,  0,  4, 38};
        tbl[2] = '{16'd3, 16'd4,  16'd4, 100, 100, 1, 10,  0,  4,  0};
        tbl[3] = '{16'd5, 16'd3,  16'd3, 100, 100, 0,  0,  0,  0, 11};
        tbl[4] = '{16'd5, 16'd8,  16'd8,  60,  50, 1,  0,  1, 16,  0};
        tbl[5] = '{16'd7, 16'd5,  16'd5,  70,  70, 1,  0,  0,  1,  0};
        tbl[6] = '{16'd3, 16'd1,  16'd1, 100, 100, 1,  0,  0,  0,  3};
        tbl[7] = '{16'd5, 16'd64, 16'd5,  80,  80, 1,  0,  0, 60,  0};
        tbl[8] = '{16'd3, 16'd3,  16'd6,  50,  90, 1,  0,  0,  4,  0};

        #1 rst = 1'b1;
        #2 check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 9; t++) run_frame(tbl[t], t);

        // Abandon a 3x3 8x8 frame after 20 pixels with an asynchronous reset.
        @(negedge clk);
        filter_size = 16'd3; img_w = 16'd8; img_h = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = pixel_t'(i);
            @(negedge clk);
        end
        chk("midframe window pending", out_valid, 1'b1);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1 check_idle_outputs("midframe reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post reset done", done, 1'b0);
            chk("post reset busy", busy, 1'b0);
        end
        run_frame(tbl[0], 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_builder.md
Name: conv_window_builder

Overview:
- Streaming producer of 5x5 windows, placed upstream of the window convolver.
- Accepts a raster-order pixel stream (row-major, one 16-bit signed pixel per transfer) and builds the sliding KxK neighbourhoods, K = 3 or 5, using line buffers.
- Emits one 25-entry window per valid output position ("valid" convolution, no padding), in the packing the convolver consumes.
- Back-pressure on both sides via valid/ready.

Parameters:
- DATA_W, 16, pixel/window element width (signed).
- MAX_W, 64, maximum image width; sets line-buffer depth.
- MAX_K, 5, maximum filter size; sets line-buffer count (MAX_K-1) and window size (MAX_K*MAX_K = 25).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches configuration and starts a frame (honoured only in IDLE).
- filter_size  in  16  K; value 3 selects 3x3, any other value selects 5x5.
- img_w  in  16  frame width in pixels, 1..MAX_W.
- img_h  in  16  frame height in pixels, >=1.
- in_valid  in  1  pixel valid.
- in_data  in  DATA_W  signed pixel.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- out_valid  out  1  window valid.
- out_window  out  25 x DATA_W  signed window, element [0:24].
- out_ready  in  1  window consumed when out_valid && out_ready.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset (async, immediate): state IDLE; out_valid=0, in_ready=0, busy=0, done=0; out_window all zero; row/col counters 0. Line-buffer contents are don't-care. Reset mid-frame abandons the frame with no done pulse.
- States:
  - IDLE: on start, latch K, img_w, img_h; clear counters; go to RUN.
  - RUN: pixel intake. After the final pixel (row img_h-1, col img_w-1) is accepted, go to FLUSH.
  - FLUSH: wait until no window is pending (out_valid=0, or out_valid && out_ready this cycle), then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy = (state != IDLE).
- A start pulse outside IDLE is ignored.
- in_ready = (state==RUN) && !(out_valid && !out_ready). This is a single-entry output stage with no bubble when out_ready is high.
- On each accepted pixel:
  - Push the pixel through the line-buffer column at index col.
  - Shift the 5x5 register window left by one column, loading the new right column from the line-buffer taps plus the new pixel.
  - Advance col; on col == img_w-1, wrap col to 0 and increment row.
- Window emission: an accepted pixel at (row, col) with row >= K-1 and col >= K-1 completes a window. out_valid rises on the next clock (latency 1 cycle from accept). out_window holds stable until the handshake completes.
- Windows never span row wrap: col resets, so no window is produced until K-1 new columns have been shifted in.
- Packing:
  - K=5: element r*5+c = pixel(row-4+r, col-4+c).
  - K=3: elements 0..8 = pixel(row-2+r, col-2+c) at index r*3+c; elements 9..24 are forced to 0.
- Window count per frame = (img_w-K+1)*(img_h-K+1). If img_w<K or img_h<K, no windows are produced, but all img_w*img_h pixels are still consumed, followed by done.
- Simultaneous events: a completing accept in the same cycle as an out handshake reloads out_valid=1 with the new window.
- FLUSH with out_valid high holds until out_ready.
- All arithmetic is unsigned on the 16-bit counters; img_w > MAX_W is unsupported (behaviour undefined).

Decomposition:
- cnn_pkg holds:
  - constants DATA_W=16, MAX_K=5, WIN_N=25;
  - typedef pixel_t (signed [DATA_W-1:0]);
  - typedef window_t (pixel_t [0:WIN_N-1]);
  - enum builder_state_t {IDLE, RUN, FLUSH, DONE}.
- One sub-module: line_buffer. It is a depth-MAX_W single-row delay with write/read at the same column index and an enable on accept. Instantiate it MAX_K-1 times in a chain.

Test Plan:
1. Basic 3x3 case. Reset, start with K=3, 8x8 frame, pixel = row*16+col, out_ready=1 -> exactly 36 windows. First window elements 0..8 = {0,1,2,16,17,18,32,33,34}, elements 9..24 = 0. Last window top-left element = 0x55. One done pulse.
2. Basic 5x5 case. K=5, 6x6 frame -> 4 windows. First window element 0 = 0, element 24 = 0x44. Fourth window element 0 = 0x11. Total frame cycles = 36 at full throughput plus the FLUSH/DONE cycles.
3. Back-pressure. K=3, 4x4 frame, out_ready held low for 10 cycles after the first out_valid -> in_ready=0 and out_window stable throughout. Release -> 4 windows, none lost or duplicated.
4. Degenerate size. K=5, 3x3 frame -> 9 pixels accepted, out_valid never asserts, done pulses once, busy falls.
5. Reset mid-frame. Assert rst mid-frame (after 20 of 64 pixels) -> outputs zero immediately, no done. A fresh start then produces a correct 36-window frame.
6. Ignored start and interleaved back-pressure. A start pulse during RUN is ignored (count unchanged). Random in_valid/out_ready toggling on an 8x8 K=5 frame -> 16 windows, all matching the golden model.
